// File: rtl/coherence_pkg.sv
// Shared coherence encodings: address/op/processor/data fields, cache state,
// issue-queue FSM states and the packed request payload.
package coherence_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned PROC_W = 2;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned REQ_W  = ADDR_W + OP_W + PROC_W + DATA_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROC_W-1:0] proc_t;
  typedef logic [DATA_W-1:0] data_t;

  // Block address codes 0001..1000 map to blocks 100..138.
  localparam addr_t ADDR_MIN = 4'b0001;
  localparam addr_t ADDR_MAX = 4'b1000;

  localparam op_t   OP_READ  = 2'b00;
  localparam op_t   OP_WRITE = 2'b01;

  localparam proc_t PROC_P1  = 2'b00;
  localparam proc_t PROC_P2  = 2'b01;

  typedef enum logic [1:0] {
    CS_INVALID  = 2'b00,
    CS_SHARED   = 2'b01,
    CS_MODIFIED = 2'b10
  } cache_state_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } iq_state_e;

  typedef struct packed {
    addr_t addr;
    op_t   op;
    proc_t proc;
    data_t data;
  } req_t;

  // A request is storable only with an in-range address, op and processor.
  function automatic logic req_legal(req_t r);
    return (r.addr >= ADDR_MIN) && (r.addr <= ADDR_MAX) &&
           ((r.op == OP_READ) || (r.op == OP_WRITE)) &&
           ((r.proc == PROC_P1) || (r.proc == PROC_P2));
  endfunction

endpackage

// File: rtl/req_issue_queue_if.sv
// Request-side and directory-side bundle of the issue queue.
// Optional stats ports exist only when REQ_ISSUE_STATS_EN is defined.
interface req_issue_queue_if;
  import coherence_pkg::*;

  logic              req_valid;
  logic              req_ready;
  addr_t             req_address;
  op_t               req_wr;
  proc_t             req_proc;
  data_t             req_data;
  logic              issue_valid;
  addr_t             issue_address;
  op_t               issue_wr;
  proc_t             issue_proc;
  data_t             issue_data;
  logic              dir_busy;
  logic              dir_done;
  logic [CNT_W-1:0]  count;
  logic              illegal;
`ifdef REQ_ISSUE_STATS_EN
  logic [STAT_W-1:0] issued_reads;
  logic [STAT_W-1:0] issued_writes;

  modport master (
    output req_valid, req_address, req_wr, req_proc, req_data, dir_busy, dir_done,
    input  req_ready, issue_valid, issue_address, issue_wr, issue_proc, issue_data,
           count, illegal, issued_reads, issued_writes
  );
  modport slave (
    input  req_valid, req_address, req_wr, req_proc, req_data, dir_busy, dir_done,
    output req_ready, issue_valid, issue_address, issue_wr, issue_proc, issue_data,
           count, illegal, issued_reads, issued_writes
  );
`else
  modport master (
    output req_valid, req_address, req_wr, req_proc, req_data, dir_busy, dir_done,
    input  req_ready, issue_valid, issue_address, issue_wr, issue_proc, issue_data,
           count, illegal
  );
  modport slave (
    input  req_valid, req_address, req_wr, req_proc, req_data, dir_busy, dir_done,
    output req_ready, issue_valid, issue_address, issue_wr, issue_proc, issue_data,
           count, illegal
  );
`endif
endinterface

// File: rtl/req_fifo.sv
// Circular request storage with registered pointers and occupancy count.
module req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [3:0]       count_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and count update; power-of-two depth makes pointer wrap free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/req_issue_queue.sv
// Request issue queue: legality filter, FIFO storage and a single-outstanding
// issue FSM toward the directory. Optional issue counters: REQ_ISSUE_STATS_EN.
module req_issue_queue
  import coherence_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  req_issue_queue_if.slave  bus_if
);

  iq_state_e        state_q, state_d;
  logic             issue_valid_q, issue_valid_d;
  req_t             issue_q, issue_d;
  logic             illegal_q, illegal_d;
  req_t             req_in;
  req_t             head;
  logic [CNT_W-1:0] count;
  logic             full, req_fire, req_ok, push, pop;

  assign req_in   = '{addr: bus_if.req_address, op: bus_if.req_wr,
                      proc: bus_if.req_proc, data: bus_if.req_data};
  assign full     = (count == CNT_W'(DEPTH));
  assign req_fire = bus_if.req_valid & ~full;
  assign req_ok   = req_legal(req_in);
  assign push     = req_fire & req_ok;
  assign pop      = (state_q == ST_ISSUE) & ~bus_if.dir_busy;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (req_in),
    .head_o  (head),
    .count_o (count)
  );

  // Issue FSM next state; head fields are captured on every entry into ISSUE.
  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    illegal_d     = req_fire & ~req_ok;
    unique case (state_q)
      ST_IDLE:  if (count != '0) state_d = ST_ISSUE;
      ST_ISSUE: if (!bus_if.dir_busy) state_d = ST_WAIT;
      ST_WAIT:  if (bus_if.dir_done) state_d = (count != '0) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    issue_valid_d = (state_d == ST_ISSUE);
    if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) issue_d = head;
  end

  // FSM and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus_if.req_ready     = ~full;
  assign bus_if.issue_valid   = issue_valid_q;
  assign bus_if.issue_address = issue_q.addr;
  assign bus_if.issue_wr      = issue_q.op;
  assign bus_if.issue_proc    = issue_q.proc;
  assign bus_if.issue_data    = issue_q.data;
  assign bus_if.count         = count;
  assign bus_if.illegal       = illegal_q;

`ifdef REQ_ISSUE_STATS_EN
  logic [STAT_W-1:0] reads_q, reads_d;
  logic [STAT_W-1:0] writes_q, writes_d;

  // Saturating per-op counters bumped on each pop of the presented head.
  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    if (pop && (issue_q.op == OP_READ) && (reads_q != '1))
      reads_d = reads_q + STAT_W'(1);
    if (pop && (issue_q.op == OP_WRITE) && (writes_q != '1))
      writes_d = writes_q + STAT_W'(1);
  end

  // Stats registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
    end
  end

  assign bus_if.issued_reads  = reads_q;
  assign bus_if.issued_writes = writes_q;
`endif

endmodule

// File: doc/req_issue_queue.md
REQ_ISSUE_QUEUE -- requirements
Module: req_issue_queue

Interface
REQ-001 DEPTH, 4, FIFO entries; power of two, 2..8.
REQ-002 Clock  in  1  single clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ReqValid  in  1  test-code request present.
REQ-005 ReqReady  out  1  queue can accept; equals not-full.
REQ-006 ReqAddress  in  4  block address code (0001=100 .. 1000=138).
REQ-007 ReqWriteOrRead  in  2  00 read, 01 write; others illegal.
REQ-008 ReqProcessor  in  2  00 P1, 01 P2; others illegal.
REQ-009 ReqData  in  4  write data code.
REQ-010 IssueValid  out  1  request presented to directory.
REQ-011 IssueAddress/IssueWriteOrRead/IssueProcessor/IssueData  out  4/2/2/4  head-entry fields.
REQ-012 DirBusy  in  1  directory cannot accept this cycle.
REQ-013 DirDone  in  1  one-cycle pulse: outstanding transaction complete.
REQ-014 Count  out  4  valid entries held.
REQ-015 Illegal  out  1  one-cycle pulse: accepted request discarded.

Function
REQ-016 Push on ReqValid && ReqReady; ReqReady from registered full only, so no push when full even with concurrent pop.
REQ-017 Request illegal if address 0000 or >1000, or WriteOrRead/Processor out of range: handshake completes, nothing stored, Illegal pulses next cycle.
REQ-018 Push and pop in same cycle: Count unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states IDLE, ISSUE, WAIT; one outstanding transaction max.
REQ-020 IDLE -> ISSUE when Count != 0; else stay.
REQ-021 ISSUE: IssueValid=1, Issue* = head fields, stable while DirBusy=1.
REQ-022 ISSUE with DirBusy=0: pop head at that edge, go WAIT.
REQ-023 WAIT: IssueValid=0; on DirDone go ISSUE if Count != 0 (post-pop), else IDLE.
REQ-024 DirDone outside WAIT ignored.
REQ-025 Latency: legal push at edge t into empty queue in IDLE -> IssueValid high in cycle after edge t+1.
REQ-026 Issue* outputs registered; hold last value when IssueValid=0.
REQ-027 Strict FIFO order; no reordering or merging of same-address requests.

Reset
REQ-028 Reset clears pointers, Count=0, FSM=IDLE, IssueValid=0, Issue* fields=0, Illegal=0, ReqReady=1 in the first cycle after the reset edge.
REQ-029 Reset mid-transaction (ISSUE or WAIT) abandons queued and outstanding requests; DirDone during reset ignored.

Configuration
REQ-030 Macro REQ_ISSUE_STATS_EN: when defined, adds outputs IssuedReads, IssuedWrites (8 bit each, saturating at 255, incremented on each ISSUE pop by op), cleared by Reset.
REQ-031 Without REQ_ISSUE_STATS_EN those ports and counters do not exist; all other behaviour identical.

Structure
REQ-032 Shared package coherence_pkg holds address, state, data, op and processor encodings plus FSM state enum; the directory and processors use the same package.
REQ-033 Storage in one sub-module req_fifo (parameter DEPTH, width 12); the FSM and legality check stay in the top level.

Verification
REQ-034 Reset; push {0011,write,P1,0100}; DirBusy=0 -> IssueValid in cycle after edge t+1, fields 0011/01/00/0100, WAIT entered.
REQ-035 Push 4 legal requests with DirBusy=1 -> Count=4, ReqReady=0; 5th ReqValid is not accepted; release DirBusy, DirDone after each -> 4 issues in push order.
REQ-036 Push address 1001 or Processor 11 -> Illegal pulses once, Count unchanged, nothing issued.
REQ-037 Full queue, simultaneous pop and ReqValid -> no push that cycle; Count 4->3; ReqReady=1 next cycle.
REQ-038 Reset asserted in WAIT with Count=2 -> next cycle IDLE, Count=0, IssueValid=0; later DirDone ignored.
REQ-039 With REQ_ISSUE_STATS_EN: 3 reads and 2 writes issued -> IssuedReads=3, IssuedWrites=2; 300 reads -> IssuedReads=255.
